muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mul/div/mod sequencer that borrows the
// core's shared add/sub ALU. Multiply is shift-and-add; div/mod use
// restoring division on magnitudes with a final sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dbz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MLOOP,
    S_ABS_A,
    S_ABS_B,
    S_DLOOP,
    S_SGN_Q,
    S_SGN_R,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_acc is the product accumulator for mul and the partial remainder for
  // div/mod; r_x is multiplicand / dividend; r_y is multiplier / quotient.
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_res;
  logic             r_dbz;
  logic             r_sa;
  logic             r_sb;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic [WIDTH-1:0] w_rem_s;
  logic             w_ge;
  logic [WIDTH-1:0] w_macc;

  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_rem_s = {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
  assign w_ge    = (w_rem_s >= r_dvs);
  assign w_macc  = r_y[0] ? alu_result : r_acc;

  assign result = r_res;
  assign dbz    = r_dbz;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and ALU operand/control steering
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (op == 2'b00) ? S_MLOOP : S_ABS_A;
      end
      S_MLOOP: begin
        busy  = 1'b1;
        alu_a = r_acc;
        alu_b = r_x;
        if (w_last) w_next = S_DONE;
      end
      S_ABS_A: begin
        busy     = 1'b1;
        alu_b    = r_x;
        alu_ctrl = 1'b1;
        w_next   = S_ABS_B;
      end
      S_ABS_B: begin
        busy     = 1'b1;
        alu_b    = r_dvs;
        alu_ctrl = 1'b1;
        w_next   = S_DLOOP;
      end
      S_DLOOP: begin
        busy     = 1'b1;
        alu_a    = w_rem_s;
        alu_b    = r_dvs;
        alu_ctrl = 1'b1;
        if (w_last) w_next = S_SGN_Q;
      end
      S_SGN_Q: begin
        busy     = 1'b1;
        alu_b    = r_y;
        alu_ctrl = 1'b1;
        w_next   = S_SGN_R;
      end
      S_SGN_R: begin
        busy     = 1'b1;
        alu_b    = r_acc;
        alu_ctrl = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_acc <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_dvs <= '0;
      r_res <= '0;
      r_dbz <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_x   <= opa;
            r_y   <= opb;
            r_dvs <= opb;
            r_sa  <= opa[WIDTH-1];
            r_sb  <= opb[WIDTH-1];
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_dbz <= 1'b0;
          end
        end
        S_MLOOP: begin
          r_acc <= w_macc;
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_res <= w_macc;
        end
        S_ABS_A: begin
          if (r_sa) r_x <= alu_result;
        end
        S_ABS_B: begin
          if (r_sb) r_dvs <= alu_result;
          r_cnt <= '0;
        end
        S_DLOOP: begin
          r_x   <= r_x << 1;
          r_acc <= w_ge ? alu_result : w_rem_s;
          r_y   <= {r_y[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_SGN_Q: begin
          if (r_sa ^ r_sb) r_y <= alu_result;
        end
        S_SGN_R: begin
          // Zero magnitude divisor means divide-by-zero; the loop still ran
          // so latency stays fixed, but its quotient/remainder are discarded.
          if (r_dvs == '0) begin
            r_res <= '0;
            r_dbz <= 1'b1;
          end else if (r_op == 2'b10) begin
            r_res <= r_sa ? alu_result : r_acc;
          end else begin
            r_res <= r_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
